// File: rtl/systolic_pkg.sv
// Shared types and sizing for the 4x4 systolic array job controller.
package systolic_pkg;

    localparam int N           = 4;
    localparam int W           = 8;
    localparam int FEED_CYCLES = 3 * N - 2;
    localparam int CNT_W       = $clog2(FEED_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        CAPTURE,
        DONE
    } state_t;

    typedef logic [N-1:0][W-1:0]         vector_t;
    typedef logic [N-1:0][N-1:0][W-1:0]  matrix_t;
    typedef logic [CNT_W-1:0]            count_t;

endpackage

// File: rtl/systolic_skew_feeder.sv
// Holds the accepted A/B operands and presents them to the array edges with
// the diagonal skew: row i and column j lag the feed counter by i (resp. j).
module systolic_skew_feeder
    import systolic_pkg::*;
(
    input  logic    i_clk,
    input  logic    i_arst_n,
    input  logic    i_load,
    input  matrix_t i_a,
    input  matrix_t i_b,
    input  logic    i_feed_active,
    input  count_t  i_t,
    output vector_t o_row,
    output vector_t o_col
);

    matrix_t a_p0;
    matrix_t b_p0;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            a_p0 <= '0;
            b_p0 <= '0;
        end else if (i_load) begin
            a_p0 <= i_a;
            b_p0 <= i_b;
        end
    end

    // Element k of row/column i reaches the edge at t = i + k; past 2N-2 no
    // pair matches, so the drain cycles come out as zeros.
    always_comb begin
        o_row = '0;
        o_col = '0;
        if (i_feed_active) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) begin
                    if (int'(i_t) == i + k) begin
                        o_row[i] = a_p0[i][k];
                        o_col[i] = b_p0[k][i];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/systolic_job_controller.sv
// Job sequencer for the systolic multiplier: accept, clear, skewed feed,
// result capture and hold until the downstream handshake.
module systolic_job_controller
    import systolic_pkg::*;
(
    input  logic    i_clk,
    input  logic    i_arst_n,
    input  matrix_t i_a,
    input  matrix_t i_b,
    input  logic    i_validInput,
    output logic    o_readyInput,
    output logic    o_peClear,
    output logic    o_peEnable,
    output vector_t o_rowIn,
    output vector_t o_colIn,
    input  matrix_t i_peResult,
    output matrix_t o_c,
    output logic    o_validResult,
    input  logic    i_readyResult,
    output logic    o_busy
);

    state_t state;
    state_t state_nxt;
    count_t cnt;
    logic   cnt_last;
    logic   accept;
    logic   feed_active;
    logic   capture;

    assign cnt_last = (cnt == count_t'(FEED_CYCLES - 1));
    assign o_busy   = (state != IDLE);

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state <= IDLE;
            cnt   <= '0;
            o_c   <= '0;
        end else begin
            state <= state_nxt;
            if (state == FEED && !cnt_last) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
            if (capture) begin
                o_c <= i_peResult;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        o_readyInput  = 1'b0;
        o_peClear     = 1'b0;
        o_peEnable    = 1'b0;
        o_validResult = 1'b0;
        accept        = 1'b0;
        feed_active   = 1'b0;
        capture       = 1'b0;
        case (state)
            IDLE: begin
                o_readyInput = 1'b1;
                if (i_validInput) begin
                    accept    = 1'b1;
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                o_peClear = 1'b1;
                state_nxt = FEED;
            end
            FEED: begin
                o_peEnable  = 1'b1;
                feed_active = 1'b1;
                if (cnt_last) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                capture   = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                o_validResult = 1'b1;
                if (i_readyResult) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    systolic_skew_feeder u_feeder (
        .i_clk         (i_clk),
        .i_arst_n      (i_arst_n),
        .i_load        (accept),
        .i_a           (i_a),
        .i_b           (i_b),
        .i_feed_active (feed_active),
        .i_t           (cnt),
        .o_row         (o_rowIn),
        .o_col         (o_colIn)
    );

endmodule

// File: tb/tb_systolic_job_controller.sv
// Bench: behavioural PE grid plus a job-level reference model, compared every cycle.
module tb_systolic_job_controller;
    import systolic_pkg::*;

    logic    i_clk = 1'b0;
    logic    i_arst_n;
    matrix_t i_a, i_b, i_peResult, o_c;
    logic    i_validInput, o_readyInput, o_peClear, o_peEnable;
    vector_t o_rowIn, o_colIn;
    logic    o_validResult, i_readyResult, o_busy;

    always #5 i_clk = ~i_clk;

    systolic_job_controller dut (
        .i_clk         (i_clk),
        .i_arst_n      (i_arst_n),
        .i_a           (i_a),
        .i_b           (i_b),
        .i_validInput  (i_validInput),
        .o_readyInput  (o_readyInput),
        .o_peClear     (o_peClear),
        .o_peEnable    (o_peEnable),
        .o_rowIn       (o_rowIn),
        .o_colIn       (o_colIn),
        .i_peResult    (i_peResult),
        .o_c           (o_c),
        .o_validResult (o_validResult),
        .i_readyResult (i_readyResult),
        .o_busy        (o_busy)
    );

    // Behavioural PE grid: operands move east/south one PE per enabled cycle.
    logic [W-1:0] g_acc [N][N];
    logic [W-1:0] g_a   [N][N];
    logic [W-1:0] g_b   [N][N];

    always @(posedge i_clk) begin : grid
        logic [W-1:0]   ai, bi;
        logic [2*W-1:0] pr;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                int jm, im;
                jm = (j > 0) ? j - 1 : 0;
                im = (i > 0) ? i - 1 : 0;
                ai = (j == 0) ? o_rowIn[i] : g_a[i][jm];
                bi = (i == 0) ? o_colIn[j] : g_b[im][j];
                pr = ai * bi;
                if (o_peClear) begin
                    g_acc[i][j] <= '0;
                    g_a[i][j]   <= '0;
                    g_b[i][j]   <= '0;
                end else if (o_peEnable) begin
                    g_acc[i][j] <= g_acc[i][j] + pr[W-1:0];
                    g_a[i][j]   <= ai;
                    g_b[i][j]   <= bi;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                i_peResult[i][j] = g_acc[i][j];
    end

    // Job-level reference: m_cnt = cycles since accept (0 idle, 3N+1 holding result).
    int      m_cnt;
    matrix_t m_a, m_b, m_c;
    int      cyc;
    int      hs_cyc;
    int      acc_q[$];
    int      vec;
    int      err;

    function automatic matrix_t matmul(input matrix_t a, input matrix_t b);
        matrix_t r;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                int s;
                s = 0;
                for (int k = 0; k < N; k++) s += a[i][k] * b[k][j];
                r[i][j] = s[W-1:0];
            end
        return r;
    endfunction

    function automatic matrix_t rand_mat();
        matrix_t r;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                r[i][j] = W'($urandom);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [N*N*W-1:0] act, input logic [N*N*W-1:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_a   = '0;
        m_b   = '0;
        m_c   = '0;
    endtask

    task automatic model_update();
        cyc++;
        if (!i_arst_n) begin
            model_reset();
        end else if (m_cnt == 0) begin
            if (i_validInput) begin
                m_cnt = 1;
                m_a   = i_a;
                m_b   = i_b;
                acc_q.push_back(cyc);
            end
        end else if (m_cnt < 3 * N + 1) begin
            if (m_cnt == 3 * N) m_c = matmul(m_a, m_b);
            m_cnt++;
        end else if (i_readyResult) begin
            m_cnt  = 0;
            hs_cyc = cyc;
        end
    endtask

    task automatic compare_all();
        vector_t er, ec;
        er = '0;
        ec = '0;
        if (m_cnt >= 2 && m_cnt <= 3 * N - 1) begin
            int t;
            t = m_cnt - 2;
            for (int i = 0; i < N; i++) begin
                int k;
                k = t - i;
                if (k >= 0 && k < N) begin
                    er[i] = m_a[i][k];
                    ec[i] = m_b[k][i];
                end
            end
        end
        chk("readyInput",  o_readyInput,  m_cnt == 0);
        chk("busy",        o_busy,        m_cnt != 0);
        chk("peClear",     o_peClear,     m_cnt == 1);
        chk("peEnable",    o_peEnable,    m_cnt >= 2 && m_cnt <= 3 * N - 1);
        chk("validResult", o_validResult, m_cnt == 3 * N + 1);
        chk("rowIn",       o_rowIn,       er);
        chk("colIn",       o_colIn,       ec);
        chk("c",           o_c,           m_c);
    endtask

    task automatic step();
        @(posedge i_clk);
        model_update();
        @(negedge i_clk);
        compare_all();
    endtask

    task automatic do_reset();
        i_arst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        step();
        i_arst_n = 1'b1;
    endtask

    task automatic run_job(input matrix_t a, input matrix_t b, input bit hold_valid,
                           input int rdy_delay, input bit skew);
        int  n0;
        bit  got;
        i_a           = a;
        i_b           = b;
        i_validInput  = 1'b1;
        i_readyResult = 1'b0;
        n0 = acc_q.size();
        for (int w = 0; w < 40 && acc_q.size() == n0; w++) step();
        chk("job_accepted", acc_q.size() > n0, 1'b1);
        if (!hold_valid) i_validInput = 1'b0;
        i_a = rand_mat();
        i_b = rand_mat();
        got = 1'b0;
        for (int w = 0; w < 40 && !got; w++) begin
            step();
            if (skew && m_cnt == 5) begin
                chk("skew_row_t3", o_rowIn, {8'h30, 8'h21, 8'h12, 8'h03});
                chk("skew_col_t3", o_colIn, {8'h83, 8'h92, 8'hA1, 8'hB0});
            end
            if (skew && m_cnt >= 9 && m_cnt <= 11) begin
                chk("drain_row", o_rowIn, '0);
                chk("drain_col", o_colIn, '0);
            end
            if (o_validResult) got = 1'b1;
        end
        chk("result_seen", got, 1'b1);
        chk("latency", cyc - acc_q[$] + 1, 3 * N + 1);
        repeat (rdy_delay) step();
        i_readyResult = 1'b1;
        step();
        i_readyResult = 1'b0;
    endtask

    initial begin
        matrix_t ia, bb, ff, ka, kb, ffexp;
        int      n0, per;
        vec = 0; err = 0; cyc = 0; hs_cyc = 0;
        i_arst_n = 1'b0; i_validInput = 1'b0; i_readyResult = 1'b0;
        i_a = '0; i_b = '0;
        model_reset();
        step(); step();
        i_arst_n = 1'b1;
        step(); step();
        chk("reset_ready", o_readyInput, 1'b1);
        chk("reset_c", o_c, '0);

        // Identity times B must return B unchanged.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ia[i][j] = (i == j) ? 8'h01 : 8'h00;
                bb[i][j] = W'(4 * i + j + 1);
                ff[i][j] = 8'hFF;
                ffexp[i][j] = 8'h04;
                ka[i][j] = W'(16 * i + j);
                kb[i][j] = W'(8'h80 + 16 * i + j);
            end
        run_job(ia, bb, 1'b0, 0, 1'b0);
        chk("ident_c", o_c, bb);

        run_job(ff, ff, 1'b0, 1, 1'b0);
        chk("ff_c", o_c, ffexp);

        run_job(ka, kb, 1'b0, 0, 1'b1);

        // Backpressure with a new request pending the whole time.
        run_job(rand_mat(), rand_mat(), 1'b1, 5, 1'b0);
        step();
        chk("bp_accept_first_idle", acc_q[$], hs_cyc + 1);
        i_validInput  = 1'b0;
        i_readyResult = 1'b1;
        repeat (3 * N + 2) step();
        i_readyResult = 1'b0;

        // Abort in the middle of FEED.
        i_a = rand_mat(); i_b = rand_mat(); i_validInput = 1'b1;
        for (int w = 0; w < 40 && m_cnt != 6; w++) step();
        chk("reached_t4", m_cnt, 6);
        i_validInput = 1'b0;
        do_reset();
        chk("abort_c_zero", o_c, '0);
        chk("abort_idle", o_busy, 1'b0);
        run_job(ff, ia, 1'b0, 0, 1'b0);
        chk("post_abort_c", o_c, ff);

        // Back-to-back jobs with both handshakes held high.
        i_validInput = 1'b1; i_readyResult = 1'b1;
        n0 = acc_q.size();
        for (int w = 0; w < 60 && acc_q.size() < n0 + 2; w++) begin
            i_a = rand_mat(); i_b = rand_mat();
            step();
        end
        per = (acc_q.size() >= n0 + 2) ? acc_q[n0 + 1] - acc_q[n0] : -1;
        chk("b2b_period", per, 3 * N + 2);
        i_validInput = 1'b0;
        repeat (3 * N + 2) step();

        // Randomized traffic with occasional asynchronous resets.
        for (int r = 0; r < 600; r++) begin
            i_validInput  = ($urandom_range(0, 3) != 0);
            i_readyResult = ($urandom_range(0, 2) != 0);
            i_a = rand_mat();
            i_b = rand_mat();
            if ($urandom_range(0, 199) == 0) do_reset();
            else step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule

// File: doc/systolic_job_controller.md
Name: systolic_job_controller

Overview:
Sequencer for the 4x4 systolic multiplier array. It accepts one matrix job (A, B) through a valid/ready handshake, clears the PE accumulators, and drives skewed row/column operands into the array edge while gating PE enable. It then captures the PE results and holds them until a downstream valid/ready handshake completes. It sits between the job source and the PE grid, and owns all array timing.

Parameters:
N, 4, array dimension (rows = cols = N)
W, 8, element and accumulator width in bits

Ports:
i_clk  in  1  clock
i_arst_n  in  1  asynchronous active-low reset
i_a  in  [N][N][W]  matrix A, row-major, sampled on accept
i_b  in  [N][N][W]  matrix B, row-major, sampled on accept
i_validInput  in  1  job request
o_readyInput  out  1  controller can accept a job
o_peClear  out  1  synchronous clear of all PE accumulators
o_peEnable  out  1  PE multiply-accumulate/forward enable
o_rowIn  out  [N][W]  west-edge operand per row
o_colIn  out  [N][W]  north-edge operand per column
i_peResult  in  [N][N][W]  PE accumulator values
o_c  out  [N][N][W]  captured result matrix
o_validResult  out  1  o_c holds a completed job
i_readyResult  in  1  downstream accepts result
o_busy  out  1  high in every state except IDLE

Behaviour:
- Reset (i_arst_n low, async): state IDLE, counter 0, operand regs 0, o_c 0, o_validResult 0, o_peClear 0, o_peEnable 0, o_rowIn/o_colIn 0. o_readyInput is 1 once reset deasserts.
- States: IDLE -> CLEAR -> FEED -> CAPTURE -> DONE -> IDLE.
- IDLE: o_readyInput=1. On i_validInput & o_readyInput, latch i_a/i_b into operand regs and go to CLEAR.
- CLEAR (1 cycle): o_peClear=1, o_peEnable=0, edge operands 0.
- FEED (3N-2 cycles; counter t = 0..3N-3): o_peEnable=1.
  - o_rowIn[i] = A[i][t-i] when 0 <= t-i < N, else 0.
  - o_colIn[j] = B[t-j][j] when 0 <= t-j < N, else 0.
  - Cycles with t > 2N-2 are drain cycles with all-zero edges.
  - Counter leaves FEED at t = 3N-3 and resets to 0.
- CAPTURE (1 cycle): o_peEnable=0. o_c <= i_peResult at the end of the cycle.
- DONE: o_validResult=1 and o_c stable. On i_readyResult go to IDLE and drop o_validResult the next cycle.
- Latency: accept edge at cycle T; o_validResult first high at T+3N+1 (T+13 for N=4). Minimum job period is 3N+2 cycles.
- Arithmetic: PE accumulation is modulo 2^W. The controller passes results unmodified.
- i_validInput outside IDLE is ignored: no sample, no queue. i_readyResult outside DONE is ignored.
- o_c retains its value after the handshake until the next CAPTURE.
- Reset mid-job: immediate return to IDLE. The partial job is discarded and o_c is zeroed.
- o_rowIn/o_colIn are combinational from the operand regs and counter, and are 0 outside FEED.

Decomposition:
- Package systolic_pkg: localparams N and W, state_t enum (IDLE, CLEAR, FEED, CAPTURE, DONE), typedefs matrix_t ([N][N][W]) and vector_t ([N][W]), and localparam FEED_CYCLES = 3*N-2.
- Sub-module systolic_skew_feeder: holds the operand regs and produces o_rowIn/o_colIn from t and a feed-active flag.
- The FSM, counter and result capture stay in the top.

Test Plan:
- Identity A, B[i][j]=4i+j+1, accept at T -> o_validResult high at T+13, o_c == B. o_readyInput low during T+1..T+13.
- All elements 0xFF in both -> every o_c element 0x04 (4*0xFE01 mod 256).
- Skew check: A[i][k]=0x10*i+k, B[k][j]=0x80+0x10*k+j, at FEED t=3 -> o_rowIn = {A[0][3],A[1][2],A[2][1],A[3][0]} = {03,12,21,30}, o_colIn = {B[3][0],B[2][1],B[1][2],B[0][3]} = {B0,A1,92,83}. At t=7..9 all edges are 0.
- Backpressure: hold i_readyResult low 5 cycles after valid, assert i_validInput throughout -> o_c stable, no accept; accept occurs the cycle after IDLE is re-entered.
- Reset pulse at FEED t=4 -> all outputs 0, state IDLE. A new job then completes with correct o_c and no residue from the aborted job.
- Two back-to-back jobs (second valid held) -> second accept is exactly 3N+2 cycles after the first, and both results are correct against a reference model.
